// File: rtl/routine_player_pkg.sv
// Shared bus layout, display constants and mode encoding for the routine bus player.
package routine_player_pkg;

    localparam int unsigned BUS_W = 46;

    localparam int unsigned RED_MSB  = 45;
    localparam int unsigned RED_LSB  = 36;
    localparam int unsigned GRN_MSB  = 35;
    localparam int unsigned GRN_LSB  = 28;
    localparam int unsigned HEX3_MSB = 27;
    localparam int unsigned HEX3_LSB = 21;
    localparam int unsigned HEX2_MSB = 20;
    localparam int unsigned HEX2_LSB = 14;
    localparam int unsigned HEX1_MSB = 13;
    localparam int unsigned HEX1_LSB = 7;
    localparam int unsigned HEX0_MSB = 6;
    localparam int unsigned HEX0_LSB = 0;

    // Segments are active-low, so all-ones is a dark digit.
    localparam logic [6:0] HEX_BLANK = 7'b1111111;

    localparam logic [BUS_W-1:0] BLANK_FRAME = {10'd0, 8'd0, HEX_BLANK, HEX_BLANK,
                                                HEX_BLANK, HEX_BLANK};

    typedef enum logic [1:0] {
        ModeLive   = 2'b00,
        ModeFrozen = 2'b01,
        ModeReplay = 2'b10
    } PlayerMode;

endpackage

// File: rtl/routine_history_ram.sv
// Frame history store: one write port, one synchronous read port, no reset on contents.
module routine_history_ram
    import routine_player_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = BUS_W
) (
    input  logic                     Clock,
    input  logic                     WrEn,
    input  logic [$clog2(DEPTH)-1:0] WrAddr,
    input  logic [WIDTH-1:0]         WrData,
    input  logic [$clog2(DEPTH)-1:0] RdAddr,
    output logic [WIDTH-1:0]         RdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (WrEn) begin
            mem[WrAddr] <= WrData;
        end
        RdData <= mem[RdAddr];
    end

endmodule

// File: rtl/routine_bus_player.sv
// Captures the routine bus on Tick, drives LEDs/segments, and replays recent frames on demand.
// Optional frame-change counter built when ROUTINE_PLAYER_CHANGE_CNT_EN is defined.
module routine_bus_player
    import routine_player_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [BUS_W-1:0]         InputBus,
    input  logic                     Tick,
    input  logic                     FreezeReq,
    input  logic                     StepBack,
    input  logic                     StepFwd,
    input  logic                     Resume,
    output logic [9:0]               LedRed,
    output logic [7:0]               LedGrn,
    output logic [6:0]               Hex3,
    output logic [6:0]               Hex2,
    output logic [6:0]               Hex1,
    output logic [6:0]               Hex0,
    output logic [1:0]               Mode,
    output logic [$clog2(DEPTH)-1:0] ReplayIndex,
    output logic [$clog2(DEPTH):0]   FillCount,
    output logic [15:0]              ChangeCount
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam logic [AW:0] FULL = FW'(DEPTH);

    PlayerMode        modeQ, modeD;
    logic [AW-1:0]    wrPtrQ, wrPtrD;
    logic [AW-1:0]    replayIdxQ, replayIdxD;
    logic [AW:0]      fillQ, fillD;
    logic [BUS_W-1:0] displayQ, displayD;
    logic [BUS_W-1:0] rdData;
    logic [AW-1:0]    rdAddr;
    logic             rdValidQ;
    logic             capture;

    assign capture = (modeQ == ModeLive) && Tick;
    assign rdAddr  = wrPtrQ - AW'(1) - replayIdxQ;

    routine_history_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BUS_W)
    ) uHistory (
        .Clock  (Clock),
        .WrEn   (capture),
        .WrAddr (wrPtrQ),
        .WrData (InputBus),
        .RdAddr (rdAddr),
        .RdData (rdData)
    );

    always_comb begin
        modeD      = modeQ;
        wrPtrD     = wrPtrQ;
        replayIdxD = replayIdxQ;
        fillD      = fillQ;
        displayD   = displayQ;

        if (capture) begin
            wrPtrD   = wrPtrQ + AW'(1);
            displayD = InputBus;
            if (fillQ != FULL) begin
                fillD = fillQ + FW'(1);
            end
        end else if (modeQ != ModeLive && rdValidQ && fillQ != '0) begin
            // rdValidQ says the word in rdData was addressed while already frozen.
            displayD = rdData;
        end

        if (Resume) begin
            if (modeQ != ModeLive) begin
                modeD      = ModeLive;
                replayIdxD = '0;
            end
        end else if (FreezeReq) begin
            if (modeQ == ModeLive) begin
                modeD      = ModeFrozen;
                replayIdxD = '0;
            end
        end else if (StepBack) begin
            if (modeQ != ModeLive && ({1'b0, replayIdxQ} + FW'(1)) < fillQ) begin
                modeD      = ModeReplay;
                replayIdxD = replayIdxQ + AW'(1);
            end
        end else if (StepFwd) begin
            if (modeQ == ModeReplay) begin
                replayIdxD = replayIdxQ - AW'(1);
                if (replayIdxQ == AW'(1)) begin
                    modeD = ModeFrozen;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            modeQ      <= ModeLive;
            wrPtrQ     <= '0;
            replayIdxQ <= '0;
            fillQ      <= '0;
            displayQ   <= BLANK_FRAME;
            rdValidQ   <= 1'b0;
        end else begin
            modeQ      <= modeD;
            wrPtrQ     <= wrPtrD;
            replayIdxQ <= replayIdxD;
            fillQ      <= fillD;
            displayQ   <= displayD;
            rdValidQ   <= (modeQ != ModeLive);
        end
    end

`ifdef ROUTINE_PLAYER_CHANGE_CNT_EN
    logic [BUS_W-1:0] lastFrameQ;
    logic [15:0]      changeCntQ;

    always_ff @(posedge Clock) begin
        if (capture) begin
            lastFrameQ <= InputBus;
        end
    end

    // An empty history means nothing to compare against, so the first capture always counts.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            changeCntQ <= '0;
        end else if (capture && (fillQ == '0 || InputBus != lastFrameQ)
                     && changeCntQ != 16'hFFFF) begin
            changeCntQ <= changeCntQ + 16'd1;
        end
    end

    assign ChangeCount = changeCntQ;
`else
    assign ChangeCount = 16'd0;
`endif

    assign LedRed      = displayQ[RED_MSB:RED_LSB];
    assign LedGrn      = displayQ[GRN_MSB:GRN_LSB];
    assign Hex3        = displayQ[HEX3_MSB:HEX3_LSB];
    assign Hex2        = displayQ[HEX2_MSB:HEX2_LSB];
    assign Hex1        = displayQ[HEX1_MSB:HEX1_LSB];
    assign Hex0        = displayQ[HEX0_MSB:HEX0_LSB];
    assign Mode        = modeQ;
    assign ReplayIndex = replayIdxQ;
    assign FillCount   = fillQ;

endmodule

// File: tb/tb_routine_bus_player.sv
// Self-checking bench: directed scenarios plus random pulses against a queue-based history model.
module tb_routine_bus_player;

    localparam int unsigned DEPTH = 16;
    localparam logic [45:0] BLANK = {10'd0, 8'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`ifdef ROUTINE_PLAYER_CHANGE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset, Tick, FreezeReq, StepBack, StepFwd, Resume;
    logic [45:0] InputBus;
    logic [9:0]  LedRed;
    logic [7:0]  LedGrn;
    logic [6:0]  Hex3, Hex2, Hex1, Hex0;
    logic [1:0]  Mode;
    logic [3:0]  ReplayIndex;
    logic [4:0]  FillCount;
    logic [15:0] ChangeCount;
    logic [45:0] shown;

    int total = 0;
    int bad = 0;

    // Model: hist[0] is the newest frame; mode 0=live 1=frozen 2=replay.
    logic [45:0] hist[$];
    int          mMode = 0, mIdx = 0, mCnt = 0;
    logic [45:0] mDisp = BLANK;
    bit          mKnown = 1'b1;
    int          edgeNo = 0, lastChange = -10;

    routine_bus_player #(.DEPTH(DEPTH)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .InputBus    (InputBus),
        .Tick        (Tick),
        .FreezeReq   (FreezeReq),
        .StepBack    (StepBack),
        .StepFwd     (StepFwd),
        .Resume      (Resume),
        .LedRed      (LedRed),
        .LedGrn      (LedGrn),
        .Hex3        (Hex3),
        .Hex2        (Hex2),
        .Hex1        (Hex1),
        .Hex0        (Hex0),
        .Mode        (Mode),
        .ReplayIndex (ReplayIndex),
        .FillCount   (FillCount),
        .ChangeCount (ChangeCount)
    );

    assign shown = {LedRed, LedGrn, Hex3, Hex2, Hex1, Hex0};

    always #5 Clock = ~Clock;

    function automatic logic [45:0] frameOf(input int k);
        return {10'(k), 8'(255 - k), 7'(k), 7'(k + 1), 7'(k + 2), 7'(k + 3)};
    endfunction

    function automatic logic [15:0] expCnt();
        return CNT_EN ? 16'(mCnt) : 16'd0;
    endfunction

    // A frozen display is trusted only two edges after the last index/mode change.
    task automatic modelEdge(input logic [45:0] bus, input bit t, input bit f, input bit b,
                             input bit w, input bit r, input bit rst);
        int preMode = mMode;
        int preIdx  = mIdx;
        int lc0     = lastChange;
        edgeNo++;
        if (rst) begin
            hist.delete();
            mMode = 0; mIdx = 0; mCnt = 0; mDisp = BLANK; mKnown = 1'b1; lastChange = edgeNo;
            return;
        end
        if (preMode == 0) begin
            if (t) begin
                if ((hist.size() == 0 || hist[0] != bus) && mCnt < 65535) mCnt++;
                hist.push_front(bus);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                mDisp = bus; mKnown = 1'b1;
            end
        end else if (hist.size() > 0) begin
            if (edgeNo >= lc0 + 2) begin
                mDisp = hist[preIdx]; mKnown = 1'b1;
            end else begin
                mKnown = 1'b0;
            end
        end
        if (r) begin
            if (preMode != 0) begin mMode = 0; mIdx = 0; end
        end else if (f) begin
            if (preMode == 0) begin mMode = 1; mIdx = 0; end
        end else if (b) begin
            if (preMode != 0 && preIdx + 1 < hist.size()) begin mIdx++; mMode = 2; end
        end else if (w) begin
            if (preMode == 2) begin mIdx--; if (mIdx == 0) mMode = 1; end
        end
        if (mMode != preMode || mIdx != preIdx) lastChange = edgeNo;
    endtask

    task automatic step(input logic [45:0] bus, input bit t, input bit f, input bit b,
                        input bit w, input bit r, input bit rst);
        InputBus = bus; Tick = t; FreezeReq = f; StepBack = b; StepFwd = w; Resume = r;
        Reset = rst;
        modelEdge(bus, t, f, b, w, r, rst);
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(InputBus, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(46'd0, 0, 0, 0, 0, 0, 1);
        step(46'd0, 0, 0, 0, 0, 0, 1);
        step(46'd0, 0, 0, 0, 0, 0, 0);
        total++; if (Mode !== 2'b00) begin bad++; $display("FAIL reset_mode got=%0h want=0", Mode); end
        total++; if (LedRed !== 10'd0) begin bad++; $display("FAIL reset_red got=%0h want=0", LedRed); end
        total++; if (LedGrn !== 8'd0) begin bad++; $display("FAIL reset_grn got=%0h want=0", LedGrn); end
        total++; if ({Hex3, Hex2, Hex1, Hex0} !== {4{7'h7F}}) begin
            bad++; $display("FAIL reset_hex got=%0h want=fffffff", {Hex3, Hex2, Hex1, Hex0});
        end
        total++; if (FillCount !== 5'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", FillCount); end
        total++; if (ReplayIndex !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", ReplayIndex); end
        total++; if (ChangeCount !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", ChangeCount); end
    endtask

    task automatic test_capture();
        step(46'h2AF07F407924, 1, 0, 0, 0, 0, 0);
        total++; if (LedRed !== 10'h2AF) begin bad++; $display("FAIL cap_red got=%0h want=2af", LedRed); end
        total++; if (LedGrn !== 8'h07) begin bad++; $display("FAIL cap_grn got=%0h want=07", LedGrn); end
        total++; if (Hex3 !== 7'h7A) begin bad++; $display("FAIL cap_hex3 got=%0h want=7a", Hex3); end
        total++; if (Hex2 !== 7'h01) begin bad++; $display("FAIL cap_hex2 got=%0h want=01", Hex2); end
        total++; if (Hex1 !== 7'h72) begin bad++; $display("FAIL cap_hex1 got=%0h want=72", Hex1); end
        total++; if (Hex0 !== 7'h24) begin bad++; $display("FAIL cap_hex0 got=%0h want=24", Hex0); end
        total++; if (FillCount !== 5'd1) begin bad++; $display("FAIL cap_fill got=%0d want=1", FillCount); end
        total++; if (ChangeCount !== (CNT_EN ? 16'd1 : 16'd0)) begin
            bad++; $display("FAIL cap_cnt got=%0d want=%0d", ChangeCount, CNT_EN);
        end
    endtask

    task automatic test_replay_walk();
        step(46'd0, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 20; k++) step(frameOf(k), 1, 0, 0, 0, 0, 0);
        total++; if (FillCount !== 5'd16) begin bad++; $display("FAIL walk_fill got=%0d want=16", FillCount); end
        total++; if (ChangeCount !== expCnt()) begin
            bad++; $display("FAIL walk_cnt got=%0d want=%0d", ChangeCount, expCnt());
        end
        step(frameOf(99), 0, 1, 0, 0, 0, 0);
        idle(2);
        total++; if (Mode !== 2'b01) begin bad++; $display("FAIL walk_frozen got=%0h want=1", Mode); end
        total++; if (shown !== frameOf(20)) begin
            bad++; $display("FAIL walk_frz_disp got=%0h want=%0h", shown, frameOf(20));
        end
        for (int i = 1; i <= 15; i++) begin
            step(frameOf(99), 0, 0, 1, 0, 0, 0);
            idle(2);
            total++; if (ReplayIndex !== 4'(i) || Mode !== 2'b10) begin
                bad++; $display("FAIL walk_idx got=%0d/%0h want=%0d/2", ReplayIndex, Mode, i);
            end
            total++; if (shown !== frameOf(20 - i)) begin
                bad++; $display("FAIL walk_disp got=%0h want=%0h", shown, frameOf(20 - i));
            end
        end
        step(frameOf(99), 0, 0, 1, 0, 0, 0);
        idle(2);
        total++; if (ReplayIndex !== 4'd15) begin bad++; $display("FAIL walk_sat got=%0d want=15", ReplayIndex); end
        total++; if (shown !== frameOf(5)) begin
            bad++; $display("FAIL walk_sat_disp got=%0h want=%0h", shown, frameOf(5));
        end
    endtask

    task automatic test_step_fwd();
        for (int i = 0; i < 13; i++) begin
            step(InputBus, 0, 0, 0, 1, 0, 0);
            idle(1);
        end
        total++; if (ReplayIndex !== 4'd2 || Mode !== 2'b10) begin
            bad++; $display("FAIL fwd_idx2 got=%0d/%0h want=2/2", ReplayIndex, Mode);
        end
        step(InputBus, 0, 0, 0, 1, 0, 0);
        step(InputBus, 0, 0, 0, 1, 0, 0);
        idle(2);
        total++; if (Mode !== 2'b01 || ReplayIndex !== 4'd0) begin
            bad++; $display("FAIL fwd_frozen got=%0h/%0d want=1/0", Mode, ReplayIndex);
        end
        total++; if (shown !== frameOf(20)) begin
            bad++; $display("FAIL fwd_disp got=%0h want=%0h", shown, frameOf(20));
        end
    endtask

    task automatic test_priority();
        step(InputBus, 0, 0, 1, 0, 0, 0);
        idle(2);
        step(frameOf(21), 0, 1, 1, 0, 1, 0);
        total++; if (Mode !== 2'b00 || ReplayIndex !== 4'd0) begin
            bad++; $display("FAIL prio_live got=%0h/%0d want=0/0", Mode, ReplayIndex);
        end
        idle(3);
        total++; if (shown !== frameOf(19)) begin
            bad++; $display("FAIL prio_hold got=%0h want=%0h", shown, frameOf(19));
        end
        step(frameOf(21), 1, 0, 0, 0, 0, 0);
        total++; if (shown !== frameOf(21)) begin
            bad++; $display("FAIL prio_tick got=%0h want=%0h", shown, frameOf(21));
        end
    endtask

    task automatic test_reset_mid_replay();
        step(InputBus, 0, 1, 0, 0, 0, 0);
        step(InputBus, 0, 0, 1, 0, 0, 0);
        idle(2);
        total++; if (Mode !== 2'b10) begin bad++; $display("FAIL rmr_pre got=%0h want=2", Mode); end
        step(InputBus, 0, 0, 0, 0, 0, 1);
        total++; if (Mode !== 2'b00 || FillCount !== 5'd0) begin
            bad++; $display("FAIL rmr_state got=%0h/%0d want=0/0", Mode, FillCount);
        end
        total++; if (shown !== BLANK) begin bad++; $display("FAIL rmr_blank got=%0h want=%0h", shown, BLANK); end
        step(InputBus, 0, 1, 0, 0, 0, 0);
        step(InputBus, 0, 0, 1, 0, 0, 0);
        idle(2);
        total++; if (Mode !== 2'b01 || ReplayIndex !== 4'd0) begin
            bad++; $display("FAIL rmr_step got=%0h/%0d want=1/0", Mode, ReplayIndex);
        end
        total++; if (shown !== BLANK) begin bad++; $display("FAIL rmr_disp got=%0h want=%0h", shown, BLANK); end
    endtask

    task automatic test_random();
        logic [63:0] r64;
        logic [45:0] bus;
        step(InputBus, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 700; c++) begin
            r64 = {$urandom, $urandom};
            bus = ($urandom_range(0, 3) == 0) ? InputBus : r64[45:0];
            step(bus, $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 19) == 0, 0);
            total++; if (Mode !== 2'(mMode)) begin
                bad++; $display("FAIL rnd_mode cyc=%0d got=%0d want=%0d", c, Mode, mMode);
            end
            total++; if (ReplayIndex !== 4'(mIdx)) begin
                bad++; $display("FAIL rnd_idx cyc=%0d got=%0d want=%0d", c, ReplayIndex, mIdx);
            end
            total++; if (FillCount !== 5'(hist.size())) begin
                bad++; $display("FAIL rnd_fill cyc=%0d got=%0d want=%0d", c, FillCount, hist.size());
            end
            total++; if (ChangeCount !== expCnt()) begin
                bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", c, ChangeCount, expCnt());
            end
            if (mKnown) begin
                total++; if (shown !== mDisp) begin
                    bad++; $display("FAIL rnd_disp cyc=%0d got=%0h want=%0h", c, shown, mDisp);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Tick = 1'b0; FreezeReq = 1'b0; StepBack = 1'b0; StepFwd = 1'b0;
        Resume = 1'b0; InputBus = '0;
        test_reset();
        test_capture();
        test_replay_walk();
        test_step_fwd();
        test_priority();
        test_reset_mid_replay();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
